sobel_edge_proc: RTL and testbench
==================================

# sobel_edge_proc

Downstream stage of gaussian_filter_proc: consumes the smoothed 8-bit gray stream (vsync/href framing) and produces a binary edge map through a 3x3 Sobel operator and a magnitude threshold. Two internal line buffers build the window. Output framing matches input framing, delayed by a fixed pipeline latency, so the block chains directly into later binary-image stages.

## Interface
- IMG_HDISP, 640, active pixels per line (line-buffer depth)
- IMG_VDISP, 480, active lines per frame
- clk  in  1  single clock; every register is on its rising edge
- rst  in  1  synchronous, active-high reset
- threshold  in  11  edge threshold, sampled at frame start
- per_img_vsync  in  1  input frame valid
- per_img_href  in  1  input pixel valid
- per_img_gray  in  8  input gray pixel
- post_img_vsync  out  1  output frame valid
- post_img_href  out  1  output pixel valid
- post_img_bit  out  1  edge flag (1 = edge)
- post_img_mag  out  8  gradient magnitude, saturated to 255

## Operation
- Window: rows r-2, r-1, r (two line buffers, depth IMG_HDISP) × cols c-2, c-1, c, where (r,c) is the current input pixel. p11..p33 are row-major, with p11 at (r-2,c-2) and p33 at (r,c).
- Gx = (p13+2·p23+p33) − (p11+2·p21+p31). Gy = (p31+2·p32+p33) − (p11+2·p12+p13). Both are 11-bit signed, range ±1020.
- mag = |Gx|+|Gy|, 11-bit unsigned, maximum 2040.
- post_img_bit = (mag > thr_q). post_img_mag = min(mag, 255).
- Output pixel (r,c) is the result for window centre (r-1,c-1), so the edge map is shifted down-right by one pixel.
- Output pixels with r<2 or c<2 are forced to post_img_bit=0 and post_img_mag=0. The result therefore never depends on stale line-buffer contents.
- Column counter:
  - Increments on each href-high cycle and clears on href low.
  - Saturates at IMG_HDISP.
  - Pixels with col ≥ IMG_HDISP are not written to the line buffers and output 0.
- Row counter:
  - Clears on the vsync rising edge and increments on each href falling edge.
  - Saturates at IMG_VDISP.
- thr_q:
  - Loaded from threshold on the per_img_vsync rising edge (0→1 seen on consecutive cycles).
  - Changes to threshold during a frame have no effect until the next frame.
  - Reset value is 0.
- Line buffers shift on every href-high cycle with col < IMG_HDISP. The newest line goes into buffer 1, and buffer 1's old content moves to buffer 2.
- No handshake or backpressure: the input is a continuous stream, and each accepted href-high pixel produces exactly one output href-high pixel.

## Timing
- Latency is exactly 4 cycles. post_img_vsync and post_img_href equal per_img_vsync and per_img_href delayed by 4 clk.
- The data for an input pixel accepted at cycle t appears at cycle t+4. Pipeline stages:
  1. line-buffer read and window shift
  2. weighted partial sums
  3. abs and add
  4. compare and saturate
- post_img_bit and post_img_mag are 0 whenever post_img_href is 0.
- Reset values:
  - All outputs 0.
  - Counters, window registers, delay lines and thr_q cleared.
  - Line-buffer RAM is not cleared.
- Reset mid-frame: outputs go to 0 on the cycle after rst is sampled high. Output resumes only after the next vsync rising edge.
- Idle gaps: any number of href-low cycles between lines, and between vsync rising and the first href, are tolerated. The window does not shift during gaps.
- vsync falls with href high (frame truncated): the counters clear at the next vsync rise. Pipelined pixels already in flight still emerge at 4-cycle latency.

## Test plan
- Flat frame, all pixels 0x80, threshold=1 → post_img_bit=0 and post_img_mag=0 for all 640×480 pixels; vsync/href are input delayed by exactly 4 cycles.
- Vertical step: col<320 → 0x00, col≥320 → 0xFF, threshold=500.
  - Output rows 2..479, cols 320 and 321 → bit=1, mag=0xFF (mag=1020).
  - All other pixels 0.
- Horizontal step: row<240 → 0x00, row≥240 → 0xFF, threshold=1019.
  - Output rows 240 and 241, cols 2..639 → bit=1.
  - With threshold=1020 on the next frame, every bit=0 (strict compare).
- Threshold latching: same vertical-step frame, threshold set to 500 before vsync rise, changed to 2047 at row 100 → edge columns stay 1 for the whole frame; the next frame (threshold 2047) is all 0.
- Reset mid-frame: assert rst for 3 cycles at row 200 → outputs 0 from the cycle after rst is sampled high. A following complete frame checks clean against the golden model (shifted Sobel, zeroed borders).
- Ragged timing: random 0–20 cycle href gaps, 5-cycle vsync-to-href lead as in the gaussian bench, real gaussian-filtered image → bit-exact match with the golden dump at threshold=100.

Source files
------------

// File: rtl/sobel_edge_proc_if.sv
// Pixel stream bundle for the Sobel edge stage: smoothed gray stream in, binary edge map out.
// The threshold travels with the input side so the whole upstream view sits on one modport.
interface sobel_edge_proc_if;
  logic [10:0] threshold;
  logic        per_img_vsync;
  logic        per_img_href;
  logic [7:0]  per_img_gray;
  logic        post_img_vsync;
  logic        post_img_href;
  logic        post_img_bit;
  logic [7:0]  post_img_mag;

  modport master (
    output threshold, per_img_vsync, per_img_href, per_img_gray,
    input  post_img_vsync, post_img_href, post_img_bit, post_img_mag
  );

  modport slave (
    input  threshold, per_img_vsync, per_img_href, per_img_gray,
    output post_img_vsync, post_img_href, post_img_bit, post_img_mag
  );
endinterface

// File: rtl/sobel_edge_proc.sv
// 3x3 Sobel edge detector on a vsync/href gray stream, fixed 4-cycle latency.
// Output (r,c) carries the window centred on (r-1,c-1); rows/cols below 2 are forced to zero.
module sobel_edge_proc #(
  parameter int IMG_HDISP = 640,
  parameter int IMG_VDISP = 480
) (
  input  logic             clk,
  input  logic             rst,
  sobel_edge_proc_if.slave bus
);
  localparam int CW = $clog2(IMG_HDISP + 1);
  localparam int RW = $clog2(IMG_VDISP + 1);
  localparam int AW = $clog2(IMG_HDISP);
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_HDISP);
  localparam logic [CW-1:0] COL_ONE = CW'(1);
  localparam logic [CW-1:0] COL_TWO = CW'(2);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_VDISP);
  localparam logic [RW-1:0] ROW_ONE = RW'(1);
  localparam logic [RW-1:0] ROW_TWO = RW'(2);

  logic [7:0]    lb1_r [IMG_HDISP];
  logic [7:0]    lb2_r [IMG_HDISP];
  logic [CW-1:0] col_r;
  logic [RW-1:0] row_r;
  logic          vsync_d_r, href_d_r, arm_r, frame_ok_r;
  logic [10:0]   thr_q_r;
  logic          vsync_rise_s, act_s, in_line_s, shift_s;
  logic [AW-1:0] col_idx_s;
  logic [7:0]    p11_r, p12_r, p13_r, p21_r, p22_r, p23_r, p31_r, p32_r, p33_r;
  logic [3:0]    vs_pipe_r, hs_pipe_r;
  logic [2:0]    ok_pipe_r;
  logic [9:0]    gx_pos_r, gx_neg_r, gy_pos_r, gy_neg_r;
  logic [9:0]    abs_x_s, abs_y_s;
  logic [10:0]   mag_r;
  logic          post_bit_r;
  logic [7:0]    post_mag_r;

  // A rise only counts once vsync has been seen low since reset, so a reset mid-frame stays muted.
  assign vsync_rise_s = bus.per_img_vsync & ~vsync_d_r & arm_r;
  assign act_s        = frame_ok_r | vsync_rise_s;
  assign in_line_s    = (col_r < COL_MAX);
  assign shift_s      = bus.per_img_href & in_line_s;
  assign col_idx_s    = col_r[AW-1:0];

  // Frame/line counters, edge detectors and per-frame threshold latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_r      <= '0;
      row_r      <= '0;
      vsync_d_r  <= 1'b0;
      href_d_r   <= 1'b0;
      arm_r      <= 1'b0;
      frame_ok_r <= 1'b0;
      thr_q_r    <= 11'd0;
    end else begin
      vsync_d_r <= bus.per_img_vsync;
      href_d_r  <= bus.per_img_href;
      arm_r     <= arm_r | ~bus.per_img_vsync;
      if (vsync_rise_s) begin
        frame_ok_r <= 1'b1;
        thr_q_r    <= bus.threshold;
      end
      if (!bus.per_img_href) begin
        col_r <= '0;
      end else if (in_line_s) begin
        col_r <= col_r + COL_ONE;
      end
      if (vsync_rise_s) begin
        row_r <= '0;
      end else if (href_d_r && !bus.per_img_href && (row_r < ROW_MAX)) begin
        row_r <= row_r + ROW_ONE;
      end
    end
  end

  // Line-buffer RAM, deliberately not cleared: border forcing hides stale rows.
  always_ff @(posedge clk) begin
    if (shift_s && !rst) begin
      lb1_r[col_idx_s] <= bus.per_img_gray;
      lb2_r[col_idx_s] <= lb1_r[col_idx_s];
    end
  end

  // Stage 1: window shift plus framing/validity delay lines.
  always_ff @(posedge clk) begin
    if (rst) begin
      {p11_r, p12_r, p13_r} <= '0;
      {p21_r, p22_r, p23_r} <= '0;
      {p31_r, p32_r, p33_r} <= '0;
      vs_pipe_r <= 4'd0;
      hs_pipe_r <= 4'd0;
      ok_pipe_r <= 3'd0;
    end else begin
      vs_pipe_r <= {vs_pipe_r[2:0], bus.per_img_vsync & act_s};
      hs_pipe_r <= {hs_pipe_r[2:0], bus.per_img_href & act_s};
      ok_pipe_r <= {ok_pipe_r[1:0],
                    shift_s & act_s & (row_r >= ROW_TWO) & (col_r >= COL_TWO)};
      if (shift_s) begin
        {p11_r, p12_r, p13_r} <= {p12_r, p13_r, lb2_r[col_idx_s]};
        {p21_r, p22_r, p23_r} <= {p22_r, p23_r, lb1_r[col_idx_s]};
        {p31_r, p32_r, p33_r} <= {p32_r, p33_r, bus.per_img_gray};
      end
    end
  end

  // Absolute gradients as |pos - neg| on the unsigned partial sums.
  always_comb begin
    abs_x_s = 10'd0;
    abs_y_s = 10'd0;
    if (gx_pos_r >= gx_neg_r) begin
      abs_x_s = gx_pos_r - gx_neg_r;
    end else begin
      abs_x_s = gx_neg_r - gx_pos_r;
    end
    if (gy_pos_r >= gy_neg_r) begin
      abs_y_s = gy_pos_r - gy_neg_r;
    end else begin
      abs_y_s = gy_neg_r - gy_pos_r;
    end
  end

  // Stages 2-4: weighted sums, magnitude, threshold compare and saturation.
  always_ff @(posedge clk) begin
    if (rst) begin
      gx_pos_r   <= 10'd0;
      gx_neg_r   <= 10'd0;
      gy_pos_r   <= 10'd0;
      gy_neg_r   <= 10'd0;
      mag_r      <= 11'd0;
      post_bit_r <= 1'b0;
      post_mag_r <= 8'd0;
    end else begin
      gx_pos_r <= {2'b00, p13_r} + {1'b0, p23_r, 1'b0} + {2'b00, p33_r};
      gx_neg_r <= {2'b00, p11_r} + {1'b0, p21_r, 1'b0} + {2'b00, p31_r};
      gy_pos_r <= {2'b00, p31_r} + {1'b0, p32_r, 1'b0} + {2'b00, p33_r};
      gy_neg_r <= {2'b00, p11_r} + {1'b0, p12_r, 1'b0} + {2'b00, p13_r};
      mag_r    <= {1'b0, abs_x_s} + {1'b0, abs_y_s};
      if (ok_pipe_r[2]) begin
        post_bit_r <= (mag_r > thr_q_r);
        post_mag_r <= (mag_r[10:8] != 3'b000) ? 8'hFF : mag_r[7:0];
      end else begin
        post_bit_r <= 1'b0;
        post_mag_r <= 8'd0;
      end
    end
  end

  assign bus.post_img_vsync = vs_pipe_r[3];
  assign bus.post_img_href  = hs_pipe_r[3];
  assign bus.post_img_bit   = post_bit_r;
  assign bus.post_img_mag   = post_mag_r;
endmodule

// File: tb/tb_sobel_edge_proc.sv
// Scoreboard bench for sobel_edge_proc on a reduced frame size; expectations come from a
// direct Sobel on the stored frame plus a 4-deep model of the output framing.
module tb_sobel_edge_proc;
  localparam int HD = 20;
  localparam int VD = 12;

  logic clk = 1'b0;
  logic rst;
  sobel_edge_proc_if bus ();

  sobel_edge_proc #(.IMG_HDISP(HD), .IMG_VDISP(VD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int         img [VD][HD+2];
  logic [8:0] sb_q [$];
  logic [3:0] dv = 4'd0;
  logic [3:0] dh = 4'd0;
  logic       live = 1'b0;
  logic       arm_m = 1'b0;
  logic       last_vs = 1'b0;
  int         thr_model = 0;
  int         errors = 0;
  int         checks = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Golden result for input pixel (r,c): {bit, saturated mag}
  function automatic logic [8:0] expect_px(input int r, input int c, input int thr);
    int gx, gy, m;
    if (r < 2 || c < 2 || c >= HD) return 9'd0;
    gx = (img[r-2][c] + 2*img[r-1][c] + img[r][c])
       - (img[r-2][c-2] + 2*img[r-1][c-2] + img[r][c-2]);
    gy = (img[r][c-2] + 2*img[r][c-1] + img[r][c])
       - (img[r-2][c-2] + 2*img[r-2][c-1] + img[r-2][c]);
    m = ((gx < 0) ? -gx : gx) + ((gy < 0) ? -gy : gy);
    return {(m > thr), (m > 255) ? 8'hFF : m[7:0]};
  endfunction

  task automatic step(input logic vs, input logic hs, input logic [7:0] g,
                      input int r, input int c, input logic rs);
    logic       rise;
    logic [8:0] e;
    @(negedge clk);
    check_eq("post_vsync", int'(bus.post_img_vsync), int'(dv[3]));
    check_eq("post_href", int'(bus.post_img_href), int'(dh[3]));
    if (bus.post_img_href) begin
      check_eq("sb_has_entry", int'(sb_q.size() > 0), 1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check_eq("edge_bit", int'(bus.post_img_bit), int'(e[8]));
        check_eq("edge_mag", int'(bus.post_img_mag), int'(e[7:0]));
      end
    end else begin
      check_eq("idle_bit", int'(bus.post_img_bit), 0);
      check_eq("idle_mag", int'(bus.post_img_mag), 0);
    end
    rst = rs;
    bus.per_img_vsync = vs;
    bus.per_img_href  = hs;
    bus.per_img_gray  = g;
    if (rs) begin
      sb_q.delete();
      live = 1'b0; arm_m = 1'b0; last_vs = 1'b0;
      dv = 4'd0; dh = 4'd0;
    end else begin
      rise = vs & ~last_vs & arm_m;
      if (rise) begin
        live = 1'b1;
        thr_model = int'(bus.threshold);
      end
      dv = {dv[2:0], vs & live};
      dh = {dh[2:0], hs & live};
      if (hs && live) sb_q.push_back(expect_px(r, c, thr_model));
      arm_m = arm_m | ~vs;
      last_vs = vs;
    end
  endtask

  // kind: 0 flat, 1 vertical step, 2 horizontal step, 3 random image
  task automatic run_frame(input int kind, input int thr0, input int thr1, input int max_gap,
                           input int extra, input int rst_row);
    int gap;
    for (int r = 0; r < VD; r++) begin
      for (int c = 0; c < HD + 2; c++) begin
        case (kind)
          0:       img[r][c] = 128;
          1:       img[r][c] = (c < HD/2) ? 0 : 255;
          2:       img[r][c] = (r < VD/2) ? 0 : 255;
          default: img[r][c] = int'($urandom_range(0, 255));
        endcase
      end
    end
    bus.threshold = 11'(thr0);
    repeat (4) step(1'b0, 1'b0, 8'd0, 0, 0, 1'b0);
    repeat (5) step(1'b1, 1'b0, 8'd0, 0, 0, 1'b0);
    for (int r = 0; r < VD; r++) begin
      if (r == VD/2) bus.threshold = 11'(thr1);
      if (r == rst_row) repeat (3) step(1'b1, 1'b0, 8'd0, r, 0, 1'b1);
      for (int c = 0; c < HD + extra; c++) step(1'b1, 1'b1, 8'(img[r][c]), r, c, 1'b0);
      gap = (max_gap > 1) ? int'($urandom_range(1, max_gap)) : 1;
      repeat (gap) step(1'b1, 1'b0, 8'd0, r, 0, 1'b0);
    end
    repeat (6) step(1'b0, 1'b0, 8'd0, 0, 0, 1'b0);
    check_eq("sb_drain", sb_q.size(), 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.threshold = 11'd0;
    bus.per_img_vsync = 1'b0;
    bus.per_img_href = 1'b0;
    bus.per_img_gray = 8'd0;
    repeat (2) @(posedge clk);
    repeat (3) step(1'b0, 1'b0, 8'd0, 0, 0, 1'b1);
    run_frame(0, 1, 1, 1, 0, -1);         // flat: no edges
    run_frame(1, 500, 500, 1, 0, -1);     // vertical step, two edge columns
    run_frame(2, 1019, 1019, 1, 0, -1);   // horizontal step, mag 1020 > 1019
    run_frame(2, 1020, 1020, 1, 0, -1);   // strict compare: no edges
    run_frame(1, 500, 2047, 1, 0, -1);    // mid-frame threshold change ignored
    run_frame(1, 2047, 2047, 1, 0, -1);   // new threshold now active
    run_frame(3, 100, 100, 20, 0, 6);     // reset mid-frame, muted until next rise
    run_frame(3, 100, 100, 20, 0, -1);    // clean frame after reset, ragged gaps
    run_frame(3, 100, 100, 20, 2, -1);    // overlong lines: extra pixels output 0
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
